// File: rtl/deser_pkg.sv
// deser_pkg: shared types for the serial frame controller.
// Optional feature macro: DESER_PARITY_EN (adds the PAR state).
package deser_pkg;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

`ifdef DESER_PARITY_EN
    typedef enum logic [1:0] {
        HUNT = 2'd0,
        LEN  = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        HUNT = 2'd0,
        LEN  = 2'd1,
        DATA = 2'd2
    } state_e;
`endif

    typedef struct packed {
        logic       first;
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

    // Odd parity: the byte plus its parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/deser_fifo.sv
// deser_fifo: small synchronous FIFO of tagged payload bytes.
// A push into a full FIFO is accepted only when a pop happens in the same cycle;
// otherwise the entry is dropped and o_dropped is raised for that cycle.
module deser_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic [9:0] i_push_entry,
    input  logic       i_pop,
    output logic [9:0] o_head,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_dropped
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   CNT_DEPTH = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW-1:0] PTR_ONE   = 1;

    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CNT_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_dropped = i_push && !w_do_push;
    assign o_head    = r_mem[r_rd_ptr];

    // Storage array: cleared on reset so the head reads zero while empty after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointers and occupancy count; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/deser_frame_ctrl.sv
// deser_frame_ctrl: hunts a serial stream for a sync word, reads a length byte and
// that many payload bytes (LSB-first), and buffers them for a valid/ready consumer.
// Optional feature macro: DESER_PARITY_EN (odd parity bit after length and payload bytes).
module deser_frame_ctrl
    import deser_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
    parameter int         MAX_LEN    = 16,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sin,
    input  logic       sin_en,
    input  logic       enable,
    output logic [7:0] byte_data,
    output logic       byte_first,
    output logic       byte_last,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       locked,
    output logic       len_err,
    output logic       parity_err,
    output logic       overflow,
    input  logic       clr_ovf
);

    localparam logic [7:0] MAX_LEN_B = MAX_LEN[7:0];

    state_e      r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_hunt_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_byte_cnt;
    logic        r_first;
    logic        r_len_err;
    logic        r_overflow;

    state_e      n_state;
    logic [2:0]  n_hunt_cnt;
    logic [2:0]  n_bit_cnt;
    logic [7:0]  n_byte_cnt;
    logic        n_first;
    logic        n_len_err;
    logic        n_par_err;

    logic [7:0]  w_shift_next;
    logic        w_len_done;
    logic [7:0]  w_len_val;
    logic        w_data_done;
    logic [7:0]  w_data_val;
    logic        w_par_fail;
    logic        w_push;
    fifo_entry_t w_push_entry;
    logic        w_pop;
    logic [9:0]  w_head_raw;
    fifo_entry_t w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_dropped;

    assign w_shift_next = {sin, r_shift[7:1]};

`ifdef DESER_PARITY_EN
    logic       r_par_err;
    logic [7:0] r_par_byte;
    logic       r_par_is_len;
    logic       w_par_strobe;
    logic       w_par_ok;

    assign w_par_strobe = enable && sin_en && (r_state == PAR);
    assign w_par_ok     = odd_parity_ok(r_par_byte, sin);
    assign w_len_done   = w_par_strobe && r_par_is_len && w_par_ok;
    assign w_len_val    = r_par_byte;
    assign w_data_done  = w_par_strobe && !r_par_is_len && w_par_ok;
    assign w_data_val   = r_par_byte;
    assign w_par_fail   = w_par_strobe && !w_par_ok;
    assign parity_err   = r_par_err;

    // Hold the just-completed byte while its parity bit is awaited.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_par_byte   <= '0;
            r_par_is_len <= 1'b0;
            r_par_err    <= 1'b0;
        end else begin
            r_par_err <= n_par_err;
            if (enable && sin_en && (r_state == LEN || r_state == DATA) && r_bit_cnt == 3'd7) begin
                r_par_byte   <= w_shift_next;
                r_par_is_len <= (r_state == LEN);
            end
        end
    end
`else
    assign w_len_done  = enable && sin_en && (r_state == LEN) && (r_bit_cnt == 3'd7);
    assign w_len_val   = w_shift_next;
    assign w_data_done = enable && sin_en && (r_state == DATA) && (r_bit_cnt == 3'd7);
    assign w_data_val  = w_shift_next;
    assign w_par_fail  = 1'b0;
    assign parity_err  = 1'b0;
`endif

    // Frame FSM next-state: hunt, length check, payload push and abort handling.
    always_comb begin
        n_state      = r_state;
        n_hunt_cnt   = r_hunt_cnt;
        n_bit_cnt    = r_bit_cnt;
        n_byte_cnt   = r_byte_cnt;
        n_first      = r_first;
        n_len_err    = 1'b0;
        n_par_err    = 1'b0;
        w_push       = 1'b0;
        w_push_entry = '0;

        if (!enable) begin
            n_state    = HUNT;
            n_hunt_cnt = 3'd0;
            n_bit_cnt  = 3'd0;
        end else if (sin_en) begin
            case (r_state)
                HUNT: begin
                    if (r_hunt_cnt == 3'd7 && w_shift_next == SYNC_WORD) begin
                        n_state    = LEN;
                        n_bit_cnt  = 3'd0;
                        n_hunt_cnt = 3'd0;
                    end else if (r_hunt_cnt != 3'd7) begin
                        n_hunt_cnt = r_hunt_cnt + 3'd1;
                    end
                end
                LEN, DATA: begin
                    n_bit_cnt = r_bit_cnt + 3'd1;
`ifdef DESER_PARITY_EN
                    if (r_bit_cnt == 3'd7) begin
                        n_state = PAR;
                    end
`endif
                end
                default: begin
                end
            endcase

            if (w_par_fail) begin
                n_par_err = 1'b1;
                n_state   = HUNT;
            end

            if (w_len_done) begin
                if (w_len_val == 8'd0 || w_len_val > MAX_LEN_B) begin
                    n_len_err = 1'b1;
                    n_state   = HUNT;
                end else begin
                    n_state    = DATA;
                    n_byte_cnt = w_len_val;
                    n_first    = 1'b1;
                    n_bit_cnt  = 3'd0;
                end
            end

            if (w_data_done) begin
                w_push             = 1'b1;
                w_push_entry.first = r_first;
                w_push_entry.last  = (r_byte_cnt == 8'd1);
                w_push_entry.data  = w_data_val;
                n_byte_cnt         = r_byte_cnt - 8'd1;
                n_first            = 1'b0;
                n_bit_cnt          = 3'd0;
                n_state            = (r_byte_cnt == 8'd1) ? HUNT : DATA;
            end
        end
    end

    // Frame state registers; everything is frozen on cycles without a bit strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= HUNT;
            r_hunt_cnt <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_first    <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            r_state    <= n_state;
            r_hunt_cnt <= n_hunt_cnt;
            r_bit_cnt  <= n_bit_cnt;
            r_byte_cnt <= n_byte_cnt;
            r_first    <= n_first;
            r_len_err  <= n_len_err;
        end
    end

    // Serial shift register: new bit enters at the top so the first bit ends at bit 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
        end else if (sin_en) begin
            r_shift <= w_shift_next;
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_dropped) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign w_pop = byte_valid && byte_ready;

    deser_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head_raw),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_dropped    (w_dropped)
    );

    assign w_head     = fifo_entry_t'(w_head_raw);
    assign byte_data  = w_head.data;
    assign byte_first = w_head.first;
    assign byte_last  = w_head.last;
    assign byte_valid = !w_empty;
    assign locked     = (r_state != HUNT);
    assign len_err    = r_len_err;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_deser_frame_ctrl.sv
// tb_deser_frame_ctrl: directed frames with hand-computed expected pops and flags.
// Works with or without DESER_PARITY_EN (parity bits are appended when defined).
module tb_deser_frame_ctrl;

    logic       clk;
    logic       reset;
    logic       sin;
    logic       sin_en;
    logic       enable;
    logic [7:0] byte_data;
    logic       byte_first;
    logic       byte_last;
    logic       byte_valid;
    logic       byte_ready;
    logic       locked;
    logic       len_err;
    logic       parity_err;
    logic       overflow;
    logic       clr_ovf;

    int nChecks = 0;
    int nFails  = 0;
    int lenErrCount = 0;
    int parErrCount = 0;
    logic [9:0] popQ[$];

`ifdef DESER_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    deser_frame_ctrl #(
        .SYNC_WORD  (8'hA5),
        .MAX_LEN    (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sin        (sin),
        .sin_en     (sin_en),
        .enable     (enable),
        .byte_data  (byte_data),
        .byte_first (byte_first),
        .byte_last  (byte_last),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .locked     (locked),
        .len_err    (len_err),
        .parity_err (parity_err),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every handshake and error pulse on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            if (byte_valid && byte_ready) popQ.push_back({byte_first, byte_last, byte_data});
            if (len_err) lenErrCount++;
            if (parity_err) parErrCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [9:0] popAt(input int i);
        if (i < popQ.size()) return popQ[i];
        return 10'h3FF;
    endfunction

    // One bit strobe: sampled at the next rising edge, inputs settle 1 time unit after it.
    task automatic applyStimulus(input logic b);
        sin    = b;
        sin_en = 1'b1;
        @(posedge clk);
        #1;
        sin_en = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] v, input bit badPar, input bit readyOnLast);
        logic [8:0] bits;
        bits = {(~^v) ^ badPar, v};
        for (int i = 0; i < NBITS; i++) begin
            if (readyOnLast && i == NBITS - 1) byte_ready = 1'b1;
            applyStimulus(bits[i]);
            if (readyOnLast) byte_ready = 1'b0;
        end
    endtask

    task automatic sendSync();
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 0; i < 8; i++) applyStimulus(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; sin = 1'b0; sin_en = 1'b0; enable = 1'b1;
        byte_ready = 1'b0; clr_ovf = 1'b0;
        #12;
        checkOutput("rst_valid",  byte_valid, 1'b0);
        checkOutput("rst_data",   {byte_first, byte_last, byte_data}, 10'h000);
        checkOutput("rst_locked", locked, 1'b0);
        checkOutput("rst_flags",  {len_err, parity_err, overflow}, 3'b000);
        #10;
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic frame A5 03 11 22 33
        byte_ready = 1'b1;
        popQ.delete();
        sendSync();
        checkOutput("t1_locked_rise", locked, 1'b1);
        sendByte(8'h03, 0, 0);
        sendByte(8'h11, 0, 0);
        checkOutput("t1_latency", {byte_valid, byte_first, byte_data}, {1'b1, 1'b1, 8'h11});
        sendByte(8'h22, 0, 0);
        sendByte(8'h33, 0, 0);
        checkOutput("t1_locked_fall", locked, 1'b0);
        idle(3);
        checkOutput("t1_npops", popQ.size(), 3);
        checkOutput("t1_pop0", popAt(0), {2'b10, 8'h11});
        checkOutput("t1_pop1", popAt(1), {2'b00, 8'h22});
        checkOutput("t1_pop2", popAt(2), {2'b01, 8'h33});

        // Noise before sync
        popQ.delete();
        applyStimulus(1'b0); applyStimulus(1'b1); applyStimulus(1'b1); applyStimulus(1'b0);
        sendSync();
        checkOutput("t2_nopop_presync", popQ.size(), 0);
        sendByte(8'h03, 0, 0);
        sendByte(8'h11, 0, 0);
        sendByte(8'h22, 0, 0);
        sendByte(8'h33, 0, 0);
        idle(3);
        checkOutput("t2_npops", popQ.size(), 3);
        checkOutput("t2_pop0", popAt(0), {2'b10, 8'h11});
        checkOutput("t2_pop2", popAt(2), {2'b01, 8'h33});

        // Length errors, then a valid one-byte frame
        popQ.delete();
        lenErrCount = 0;
        sendSync();
        sendByte(8'h00, 0, 0);
        checkOutput("t3_len0_pulse", len_err, 1'b1);
        idle(1);
        checkOutput("t3_len0_count", lenErrCount, 1);
        checkOutput("t3_len0_unlock", locked, 1'b0);
        sendSync();
        sendByte(8'h11, 0, 0);
        idle(2);
        checkOutput("t3_len17_count", lenErrCount, 2);
        checkOutput("t3_empty", byte_valid, 1'b0);
        sendSync();
        sendByte(8'h01, 0, 0);
        sendByte(8'h5A, 0, 0);
        idle(3);
        checkOutput("t3_npops", popQ.size(), 1);
        checkOutput("t3_pop0", popAt(0), {2'b11, 8'h5A});

        // Overflow with consumer stalled
        popQ.delete();
        byte_ready = 1'b0;
        sendSync();
        sendByte(8'h06, 0, 0);
        for (int i = 1; i <= 6; i++) sendByte(i[7:0], 0, 0);
        checkOutput("t4_ovf_set", overflow, 1'b1);
        checkOutput("t4_unlock", locked, 1'b0);
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        checkOutput("t4_ovf_clr", overflow, 1'b0);
        checkOutput("t4_head", {byte_valid, byte_first, byte_data}, {1'b1, 1'b1, 8'h01});
        sendSync();
        sendByte(8'h02, 0, 0);
        sendByte(8'hAA, 0, 1);
        checkOutput("t4_poppush_full", overflow, 1'b0);
        sendByte(8'hBB, 0, 0);
        checkOutput("t4_ovf_again", overflow, 1'b1);
        byte_ready = 1'b1;
        idle(6);
        checkOutput("t4_npops", popQ.size(), 5);
        checkOutput("t4_pop0", popAt(0), {2'b10, 8'h01});
        checkOutput("t4_pop3", popAt(3), {2'b00, 8'h04});
        checkOutput("t4_pop4", popAt(4), {2'b10, 8'hAA});
        checkOutput("t4_drained", byte_valid, 1'b0);
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;

        // Abort via enable mid-payload
        popQ.delete();
        byte_ready = 1'b0;
        sendSync();
        sendByte(8'h05, 0, 0);
        sendByte(8'hC1, 0, 0);
        sendByte(8'hC2, 0, 0);
        enable = 1'b0;
        @(posedge clk); #1;
        checkOutput("t5_abort_unlock", locked, 1'b0);
        enable = 1'b1;
        checkOutput("t5_kept", byte_valid, 1'b1);
        byte_ready = 1'b1;
        idle(4);
        checkOutput("t5_npops", popQ.size(), 2);
        checkOutput("t5_pop0", popAt(0), {2'b10, 8'hC1});
        checkOutput("t5_pop1", popAt(1), {2'b00, 8'hC2});
        sendSync();
        sendByte(8'h01, 0, 0);
        sendByte(8'h77, 0, 0);
        idle(3);
        checkOutput("t5_next_frame", popAt(2), {2'b11, 8'h77});

`ifdef DESER_PARITY_EN
        // Bad parity on the second payload byte
        popQ.delete();
        parErrCount = 0;
        sendSync();
        sendByte(8'h03, 0, 0);
        sendByte(8'h11, 0, 0);
        sendByte(8'h22, 1, 0);
        checkOutput("t6_par_pulse", parity_err, 1'b1);
        checkOutput("t6_unlock", locked, 1'b0);
        idle(3);
        checkOutput("t6_par_count", parErrCount, 1);
        checkOutput("t6_npops", popQ.size(), 1);
        checkOutput("t6_pop0", popAt(0), {2'b10, 8'h11});
`else
        checkOutput("t6_no_parity_err", parErrCount, 0);
`endif

        // Asynchronous reset mid-frame
        byte_ready = 1'b0;
        sendSync();
        sendByte(8'h03, 0, 0);
        sendByte(8'h33, 0, 0);
        checkOutput("t7_pre_state", {byte_valid, locked}, 2'b11);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t7_rst_clear", {byte_valid, locked, overflow, byte_data}, 11'h000);
        #3;
        reset = 1'b1;
        idle(2);
        checkOutput("t7_after_rst", {byte_valid, locked}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/deser_frame_ctrl.md
# deser_frame_ctrl

Frame controller for the serial receive path. Hunts a serial bit stream for a sync word, then reads a length byte and that many payload bytes. Bytes are assembled LSB-first, matching the existing deserializer's bit ordering. Completed bytes are buffered in a small FIFO and presented to the downstream consumer over a valid/ready handshake, with first/last-of-frame tags.

## Interface
Parameters:
- SYNC_WORD, 8'hA5, sync pattern in assembled byte order (first received bit = bit 0)
- MAX_LEN, 16, largest legal payload length in bytes (1..255)
- FIFO_DEPTH, 4, output buffer entries (power of two, ≥2)

Ports (reset reset, asynchronous, active-low; clock clk):
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- sin  in  1  serial data bit
- sin_en  in  1  bit strobe; sin sampled on clk edges where sin_en=1
- enable  in  1  0 = abort current frame and hold in HUNT
- byte_data  out  8  head-of-FIFO byte
- byte_first  out  1  head byte is first payload byte of a frame
- byte_last  out  1  head byte is last payload byte of a frame
- byte_valid  out  1  FIFO non-empty
- byte_ready  in  1  consumer accepts head when byte_valid & byte_ready
- locked  out  1  state is LEN or DATA
- len_err  out  1  one-cycle pulse: length 0 or > MAX_LEN
- parity_err  out  1  one-cycle pulse: parity failure (0 when parity compiled out)
- overflow  out  1  sticky: byte dropped on full FIFO
- clr_ovf  in  1  synchronous clear of overflow

## Operation
- Reset values: all outputs 0, state HUNT, FIFO empty, shift register 0, counters 0.
- Shift register: on each sin_en, sin enters bit 7 and the register shifts right, so after 8 bits the first-received bit sits at bit 0.
- HUNT: sliding compare against SYNC_WORD after every strobe. On a match, go to LEN and reset the bit counter. Requires ≥8 strobes since entering HUNT; stale shift bits never match.
- LEN: collect 8 bits into L.
  - L==0 or L>MAX_LEN: pulse len_err and return to HUNT.
  - Otherwise go to DATA, with byte counter = L.
- DATA: on every 8th bit, push {first,last,data} into the FIFO and decrement the byte counter.
  - first = first byte of the frame; last = counter reaches 0.
  - After the last byte, go to HUNT.
- FIFO full on push: byte dropped, overflow set. The frame continues to be counted, so alignment is kept.
- Pop and push in the same cycle while full: the push is accepted and overflow is not set.
- enable=0: synchronous move to HUNT, bit counter cleared. FIFO contents kept and still drain.
- clr_ovf and a drop in the same cycle: overflow stays set (set wins).
- sin_en=0 cycles: all frame state frozen; handshake unaffected.

## Timing
- A payload byte is written into the FIFO at the clk edge sampling its final bit. byte_valid/byte_data are visible after that edge, i.e. 1 cycle latency from the last bit strobe.
- byte_valid depends only on registered FIFO state; no combinational path from byte_ready to byte_valid.
- len_err and parity_err assert for exactly one cycle, the cycle after the offending bit is sampled.
- locked rises the cycle after the sync match and falls the cycle after the last byte, error, or enable=0.
- Back-to-back frames: HUNT can match a new sync starting with the next strobe after the last byte.
- Asynchronous reset mid-frame clears state, FIFO and sticky flags immediately.

## Configuration
- DESER_PARITY_EN defined:
  - The length byte and each payload byte are followed by one odd-parity bit, checked at the strobe after the byte's 8th bit.
  - A payload byte is pushed only after its parity passes.
  - On failure: pulse parity_err, do not push, return to HUNT. Already-pushed bytes of the frame stay in the FIFO.
- DESER_PARITY_EN undefined: no parity bits expected; parity_err tied to 0.

## Structure
- Package deser_pkg: state enum (HUNT, LEN, DATA, plus PAR when parity is enabled), FIFO entry struct {first, last, data[7:0]}, default SYNC_WORD constant.
- Sub-module deser_fifo: synchronous FIFO of entries with push/pop/full/empty, parameterised on FIFO_DEPTH. The controller FSM, shift register and counters stay in the top module.

## Test plan
- Reset, then bits of A5, length 03, bytes 11 22 33 with byte_ready=1 → three pops: 11 (first=1), 22, 33 (last=1); locked low after 33.
- Noise bits 0,1,1,0 before the sync → same output; no pop before the sync completes.
- Length 00, then length 17 with MAX_LEN=16 → len_err pulses once per frame; FIFO empty; next valid frame decodes correctly.
- byte_ready=0, frame of 6 bytes with FIFO_DEPTH=4 → bytes 1–4 held, bytes 5–6 dropped, overflow=1; clr_ovf clears it; a pop plus push while full sets no overflow.
- enable=0 mid-payload after 2 bytes → those 2 bytes still drain; no last tag; the next frame after enable=1 decodes.
- With DESER_PARITY_EN: bad parity on the 2nd byte → byte 1 popped, parity_err pulse, byte 2 absent, return to HUNT.
